// File: rtl/x_uart_pkg.sv
// x_uart_pkg: shared types and constants for the x_uart transmit path.
package x_uart_pkg;
    typedef enum logic {IDLE, LOCK} x_uart_arb_state_t;
    localparam int X_UART_BYTE_W = 8;
endpackage

// File: rtl/x_rr_pick.sv
// x_rr_pick: combinational round-robin pick, first set request at or after i_ptr with wrap.
module x_rr_pick #(
    parameter int p_num = 4
) (
    input  logic [p_num-1:0]         i_req,
    input  logic [$clog2(p_num)-1:0] i_ptr,
    output logic [p_num-1:0]         o_gnt,
    output logic                     o_any
);
    logic [2*p_num-1:0] dbl_req, dbl_gnt;
    logic [p_num-1:0]   rot_req, rot_gnt;
    // rotate so i_ptr sits at bit 0, isolate the lowest set bit, rotate back
    assign dbl_req = {i_req, i_req} >> i_ptr;
    assign rot_req = dbl_req[p_num-1:0];
    assign rot_gnt = rot_req & (~rot_req + 1'b1);
    assign dbl_gnt = {rot_gnt, rot_gnt} << i_ptr;
    assign o_gnt   = dbl_gnt[2*p_num-1:p_num];
    assign o_any   = |i_req;
endmodule

// File: rtl/x_uart_tx_arb.sv
// x_uart_tx_arb: round-robin, message-locked arbiter sharing one x_uart_tx among p_num requesters.
// Define X_UART_TX_ARB_TIMEOUT_EN to force-release a lock stalled for p_timeout cycles.
module x_uart_tx_arb
    import x_uart_pkg::*;
#(
    parameter int p_num     = 4,
    parameter int p_timeout = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [p_num-1:0]                 i_valid,
    input  logic [X_UART_BYTE_W*p_num-1:0]   i_data,
    input  logic [p_num-1:0]                 i_last,
    output logic [p_num-1:0]                 o_accept,
    output logic                             o_valid,
    output logic [X_UART_BYTE_W-1:0]         o_data,
    input  logic                             i_accept,
    output logic [p_num-1:0]                 o_grant,
    output logic                             o_timeout
);
    localparam int PW = $clog2(p_num);

    x_uart_arb_state_t state_q, state_d;
    logic [p_num-1:0]  grant_q, grant_d, pick_gnt;
    logic [PW-1:0]     ptr_q, ptr_d, owner, next_ptr;
    logic              pick_any, done;

    x_rr_pick #(.p_num(p_num)) u_pick (
        .i_req (i_valid),
        .i_ptr (ptr_q),
        .o_gnt (pick_gnt),
        .o_any (pick_any)
    );

    // grant_q is all-zero in IDLE, so the mux naturally yields zero outputs there
    always_comb begin
        o_data = '0;
        owner  = '0;
        for (int n = 0; n < p_num; n++) begin
            if (grant_q[n]) begin
                o_data = i_data[X_UART_BYTE_W*n +: X_UART_BYTE_W];
                owner  = PW'(n);
            end
        end
    end

    assign o_valid  = |(i_valid & grant_q);
    assign o_accept = grant_q & {p_num{i_accept}};
    assign o_grant  = grant_q;
    assign done     = o_valid & i_accept & |(i_last & grant_q);
    assign next_ptr = (owner == PW'(p_num-1)) ? '0 : owner + 1'b1;

`ifdef X_UART_TX_ARB_TIMEOUT_EN
    localparam int CW = $clog2(p_timeout+1);
    logic [CW-1:0] cnt_q, cnt_d;
    // fires on the p_timeout-th consecutive stalled cycle of the owner
    assign o_timeout = (state_q == LOCK) && !o_valid && (cnt_q == CW'(p_timeout-1));
    assign cnt_d     = ((state_q == LOCK) && !o_valid && !o_timeout) ? cnt_q + 1'b1 : '0;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    assign o_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (pick_any) begin
                state_d = LOCK;
                grant_d = pick_gnt;
            end
        end else if (done || o_timeout) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = next_ptr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: tb/tb_x_uart_tx_arb.sv
// tb_x_uart_tx_arb: directed self-checking bench for x_uart_tx_arb (p_num=4, p_timeout=8).
module tb_x_uart_tx_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  valid, last, accept, grant;
    logic [31:0] data;
    logic        acc, ovalid, otimeout;
    logic [7:0]  odata;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    x_uart_tx_arb #(.p_num(4), .p_timeout(8)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (valid),
        .i_data    (data),
        .i_last    (last),
        .o_accept  (accept),
        .o_valid   (ovalid),
        .o_data    (odata),
        .i_accept  (acc),
        .o_grant   (grant),
        .o_timeout (otimeout)
    );

    task automatic setreq(input int n, input logic v, input logic [7:0] d, input logic l);
        valid[n]      = v;
        data[8*n +: 8] = d;
        last[n]       = l;
    endtask

    // compares {grant, valid, data, accept, timeout} against hand-derived values
    task automatic expect_o(input string tag, input logic [3:0] g, input logic v,
                            input logic [7:0] d, input logic [3:0] a, input logic t);
        logic [17:0] o, e;
        o = {grant, ovalid, odata, accept, otimeout};
        e = {g, v, d, a, t};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    initial begin
        rst = 1'b1; valid = '0; data = '0; last = '0; acc = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 expect_o("reset", 4'h0, 0, 8'h00, 4'h0, 0);
        // single message from requester 0
        @(negedge clk); setreq(0, 1, 8'h41, 0);
        #1 expect_o("t1_idle", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("t1_b41", 4'h1, 1, 8'h41, 4'h1, 0);
        @(negedge clk); setreq(0, 1, 8'h42, 0);
        #1 expect_o("t1_b42", 4'h1, 1, 8'h42, 4'h1, 0);
        @(negedge clk); setreq(0, 1, 8'h43, 1);
        #1 expect_o("t1_b43", 4'h1, 1, 8'h43, 4'h1, 0);
        // backpressure on requester 3
        @(negedge clk); setreq(0, 0, 8'h43, 0); setreq(3, 1, 8'h5A, 1); acc = 1'b0;
        #1 expect_o("t1_release", 4'h0, 0, 8'h00, 4'h0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1 expect_o("bp_stall", 4'h8, 1, 8'h5A, 4'h0, 0);
        end
        @(negedge clk); acc = 1'b1;
        #1 expect_o("bp_accept", 4'h8, 1, 8'h5A, 4'h8, 0);
        // round robin: 0 and 2 together with ptr=0, then again with ptr=3
        @(negedge clk); setreq(3, 0, 8'h5A, 0); setreq(0, 1, 8'hA0, 1); setreq(2, 1, 8'hC2, 1);
        #1 expect_o("rr_idle", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("rr_first0", 4'h1, 1, 8'hA0, 4'h1, 0);
        @(negedge clk); setreq(0, 0, 8'hA0, 0);
        #1 expect_o("rr_gap", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("rr_then2", 4'h4, 1, 8'hC2, 4'h4, 0);
        @(negedge clk); setreq(2, 1, 8'hC3, 1); setreq(0, 1, 8'hA1, 1);
        #1 expect_o("rr_gap2", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("rr_wrap0", 4'h1, 1, 8'hA1, 4'h1, 0);
        @(negedge clk); setreq(0, 0, 8'hA1, 0);
        #1 expect_o("rr_gap3", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("rr_then2b", 4'h4, 1, 8'hC3, 4'h4, 0);
        // lock: requester 1 sends 4 bytes, requester 0 arrives mid-message
        @(negedge clk); setreq(2, 0, 8'hC3, 0); setreq(1, 1, 8'h10, 0);
        #1 expect_o("lk_idle", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("lk_b10", 4'h2, 1, 8'h10, 4'h2, 0);
        @(negedge clk); setreq(1, 1, 8'h11, 0);
        #1 expect_o("lk_b11", 4'h2, 1, 8'h11, 4'h2, 0);
        @(negedge clk); setreq(1, 1, 8'h12, 0); setreq(0, 1, 8'hB0, 1);
        #1 expect_o("lk_b12_hold0", 4'h2, 1, 8'h12, 4'h2, 0);
        @(negedge clk); setreq(1, 1, 8'h13, 1);
        #1 expect_o("lk_b13_hold0", 4'h2, 1, 8'h13, 4'h2, 0);
        @(negedge clk); setreq(1, 0, 8'h13, 0);
        #1 expect_o("lk_gap", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("lk_grant0", 4'h1, 1, 8'hB0, 4'h1, 0);
        // owner 1 stalls mid-message while requester 2 waits
        @(negedge clk); setreq(0, 0, 8'hB0, 0); setreq(1, 1, 8'h20, 0); setreq(2, 1, 8'hD0, 1);
        #1 expect_o("st_idle", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("st_b20", 4'h2, 1, 8'h20, 4'h2, 0);
        @(negedge clk); setreq(1, 0, 8'h20, 0);
`ifdef X_UART_TX_ARB_TIMEOUT_EN
        #1 expect_o("to_stall1", 4'h2, 0, 8'h20, 4'h2, 0);
        for (int k = 2; k < 8; k++) begin
            @(negedge clk);
            #1 expect_o("to_stall", 4'h2, 0, 8'h20, 4'h2, 0);
        end
        @(negedge clk);
        #1 expect_o("to_pulse", 4'h2, 0, 8'h20, 4'h2, 1);
        @(negedge clk);
        #1 expect_o("to_idle", 4'h0, 0, 8'h00, 4'h0, 0);
`else
        #1 expect_o("hold_stall1", 4'h2, 0, 8'h20, 4'h2, 0);
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            #1 expect_o("hold_stall", 4'h2, 0, 8'h20, 4'h2, 0);
        end
        @(negedge clk); setreq(1, 1, 8'h21, 1);
        #1 expect_o("hold_resume", 4'h2, 1, 8'h21, 4'h2, 0);
        @(negedge clk); setreq(1, 0, 8'h21, 0);
        #1 expect_o("hold_idle", 4'h0, 0, 8'h00, 4'h0, 0);
`endif
        @(negedge clk);
        #1 expect_o("st_grant2", 4'h4, 1, 8'hD0, 4'h4, 0);
        // async reset while requester 3 holds the lock
        @(negedge clk); setreq(2, 0, 8'hD0, 0); setreq(3, 1, 8'h30, 0);
        #1 expect_o("rs_idle", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("rs_lock3", 4'h8, 1, 8'h30, 4'h8, 0);
        #1 rst = 1'b1;
        #1 expect_o("rs_async", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk); rst = 1'b0; setreq(0, 1, 8'hE0, 1);
        #1 expect_o("rs_released", 4'h0, 0, 8'h00, 4'h0, 0);
        @(negedge clk);
        #1 expect_o("rs_ptr0", 4'h1, 1, 8'hE0, 4'h1, 0);
        @(negedge clk); valid = '0; last = '0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
